run_control: RTL and testbench

RUN_CONTROL -- requirements
Module: run_control

---
 rtl/stopwatch_pkg.sv | 18 +
 rtl/sync_debounce.sv | 46 ++++
 rtl/run_control.sv | 119 +++++++++++
 tb/tb_run_control.sv | 105 ++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch run/pause controller: run-state
// encoding, default debounce and long-press sample counts.
package stopwatch_pkg;

    typedef enum logic {
        RUN  = 1'b0,
        HOLD = 1'b1
    } run_state_e;

    localparam int DB_SAMPLES_DEFAULT   = 16;
    localparam int LONG_SAMPLES_DEFAULT = 2000;

    // Counter width able to hold the value n without wrapping.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/sync_debounce.sv
// Single-bit 2-flop synchronizer followed by a tick-gated debounce counter;
// the level changes after DB_SAMPLES consecutive mismatching ticks.
module sync_debounce
    import stopwatch_pkg::*;
#(
    parameter int DB_SAMPLES = DB_SAMPLES_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic raw,
    output logic level
);

    localparam int CW = cnt_width(DB_SAMPLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_SAMPLES - 1);

    logic          meta;
    logic          stable;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta   <= 1'b0;
            stable <= 1'b0;
            cnt    <= '0;
            level  <= 1'b0;
        end else begin
            meta   <= raw;
            stable <= meta;
            if (tick) begin
                if (stable == level) begin
                    cnt <= '0;
                end else if (cnt == CNT_LAST) begin
                    // Terminal count: accept the new level and restart, so the
                    // counter never runs past its last value.
                    level <= stable;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/run_control.sv
// Pause/run/clear controller for the stopwatch: debounced buttons and
// switches drive a two-state FSM. Optional long-press clear: RUN_CONTROL_LONGPRESS_EN.
//
//   state | meaning
//   ------+------------------------------------------
//   RUN   | time counter running (paused=0 unless adj)
//   HOLD  | time counter held    (paused=1)
module run_control
    import stopwatch_pkg::*;
#(
    parameter int DB_SAMPLES   = DB_SAMPLES_DEFAULT,
    parameter int LONG_SAMPLES = LONG_SAMPLES_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       btnS,
    input  logic       btnR,
    input  logic [1:0] sw,
    output logic       paused,
    output logic       clr,
    output logic       sel,
    output logic       adj
);

    if (DB_SAMPLES < 2 || DB_SAMPLES > 65535 || LONG_SAMPLES <= DB_SAMPLES) begin : g_bad_params
        $error("run_control: need 2 <= DB_SAMPLES <= 65535 and LONG_SAMPLES > DB_SAMPLES");
    end

    logic s_lvl, r_lvl, adj_lvl;
    logic s_prev, r_prev, adj_prev;
    logic s_rise, r_rise, adj_fall;
    logic s_evt, lp_clr;

    run_state_e state, state_nxt;
    logic       paused_nxt, clr_nxt;

    sync_debounce #(.DB_SAMPLES(DB_SAMPLES)) u_db_s   (.clk(clk), .rst(rst), .tick(tick), .raw(btnS),  .level(s_lvl));
    sync_debounce #(.DB_SAMPLES(DB_SAMPLES)) u_db_r   (.clk(clk), .rst(rst), .tick(tick), .raw(btnR),  .level(r_lvl));
    sync_debounce #(.DB_SAMPLES(DB_SAMPLES)) u_db_sel (.clk(clk), .rst(rst), .tick(tick), .raw(sw[0]), .level(sel));
    sync_debounce #(.DB_SAMPLES(DB_SAMPLES)) u_db_adj (.clk(clk), .rst(rst), .tick(tick), .raw(sw[1]), .level(adj_lvl));

    assign adj      = adj_lvl;
    assign s_rise   = s_lvl & ~s_prev;
    assign r_rise   = r_lvl & ~r_prev;
    assign adj_fall = ~adj_lvl & adj_prev;

`ifdef RUN_CONTROL_LONGPRESS_EN
    localparam int LW = cnt_width(LONG_SAMPLES);
    localparam logic [LW-1:0] LONG_LAST = LW'(LONG_SAMPLES - 1);

    logic [LW-1:0] lp_cnt;
    logic          lp_fire;
    logic          lp_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            lp_cnt  <= '0;
            lp_fire <= 1'b0;
            lp_done <= 1'b0;
        end else begin
            lp_fire <= 1'b0;
            if (!s_lvl) begin
                lp_cnt  <= '0;
                lp_done <= 1'b0;
            end else if (tick && !lp_done) begin
                if (lp_cnt == LONG_LAST) begin
                    lp_fire <= 1'b1;
                    lp_done <= 1'b1;
                end else begin
                    lp_cnt <= lp_cnt + LW'(1);
                end
            end
        end
    end

    // A press is only known to be short once it ends, so the toggle moves to release.
    assign s_evt  = ~s_lvl & s_prev & ~lp_done;
    assign lp_clr = lp_fire & (state == HOLD) & ~adj_lvl;
`else
    assign s_evt  = s_rise;
    assign lp_clr = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= RUN;
            paused   <= 1'b0;
            clr      <= 1'b0;
            s_prev   <= 1'b0;
            r_prev   <= 1'b0;
            adj_prev <= 1'b0;
        end else begin
            state    <= state_nxt;
            paused   <= paused_nxt;
            clr      <= clr_nxt;
            s_prev   <= s_lvl;
            r_prev   <= r_lvl;
            adj_prev <= adj_lvl;
        end
    end

    always_comb begin
        state_nxt = state;
        if (r_rise) begin
            state_nxt = RUN;
        end else if (adj_fall) begin
            state_nxt = HOLD;
        end else if (!adj_lvl && s_evt) begin
            state_nxt = (state == RUN) ? HOLD : RUN;
        end
    end

    always_comb begin
        paused_nxt = (state_nxt == HOLD) || adj_lvl;
        clr_nxt    = r_rise || lp_clr;
    end

endmodule

// File: tb/tb_run_control.sv
// Scoreboard bench for run_control (DB_SAMPLES=4, LONG_SAMPLES=10, tick every cycle).
// Build with RUN_CONTROL_LONGPRESS_EN to exercise the long-press sequence instead.
module tb_run_control;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b1;
    logic       btnS = 1'b0;
    logic       btnR = 1'b0;
    logic [1:0] sw = 2'b00;
    logic       paused, clr, sel, adj;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        string tag;
        logic  paused;
        logic  clr;
        logic  sel;
        logic  adj;
    } exp_t;

    exp_t sb[$];

    run_control #(.DB_SAMPLES(4), .LONG_SAMPLES(10)) dut (
        .clk(clk), .rst(rst), .tick(tick), .btnS(btnS), .btnR(btnR),
        .sw(sw), .paused(paused), .clr(clr), .sel(sel), .adj(adj)
    );

    always #5 clk = ~clk;

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", tag, obs, exp, $time);
        end
    endtask

    // Each pushed entry is the expected output after the next rising edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check_bit({e.tag, ".paused"}, paused, e.paused);
            check_bit({e.tag, ".clr"},    clr,    e.clr);
            check_bit({e.tag, ".sel"},    sel,    e.sel);
            check_bit({e.tag, ".adj"},    adj,    e.adj);
        end
    end

    task automatic step(input logic s, input logic r, input logic [1:0] w, input logic rs,
                        input logic ep, input logic ec, input logic es, input logic ea,
                        input string tag);
        exp_t e;
        @(negedge clk);
        btnS = s;
        btnR = r;
        sw   = w;
        rst  = rs;
        e.tag = tag; e.paused = ep; e.clr = ec; e.sel = es; e.adj = ea;
        sb.push_back(e);
    endtask

    initial begin
        for (int k = 1; k <= 3; k++) step(0, 0, 2'b00, 1, 0, 0, 0, 0, "reset");
        for (int k = 1; k <= 3; k++) step(0, 0, 2'b00, 0, 0, 0, 0, 0, "idle");

`ifndef RUN_CONTROL_LONGPRESS_EN
        // Short glitch below the debounce length: nothing happens.
        for (int k = 1; k <= 13; k++) step(k <= 3, 0, 2'b00, 0, 0, 0, 0, 0, "short_glitch");
        // Long hold: one toggle to HOLD at edge 7, nothing on release.
        for (int k = 1; k <= 30; k++) step(k <= 20, 0, 2'b00, 0, k >= 7, 0, 0, 0, "hold_toggle");
        // btnS and btnR together from HOLD: clear wins.
        for (int k = 1; k <= 20; k++) step(k <= 10, k <= 10, 2'b00, 0, k < 7, k == 7, 0, 0, "s_and_r");
        // ADJ forces pause and blocks btnS; leaving ADJ lands in HOLD.
        for (int k = 1; k <= 10; k++) step(0, 0, 2'b10, 0, k >= 7, 0, 0, k >= 6, "adj_on");
        for (int k = 1; k <= 18; k++) step(k <= 8, 0, 2'b10, 0, 1, 0, 0, 1, "adj_btn_ignored");
        for (int k = 1; k <= 12; k++) step(0, 0, 2'b00, 0, 1, 0, 0, k < 6, "adj_off_hold");
        for (int k = 1; k <= 18; k++) step(k <= 10, 0, 2'b00, 0, k < 7, 0, 0, 0, "hold_to_run");
        // SEL debounce, glitch then stable level and back.
        for (int k = 1; k <= 8; k++)  step(0, 0, (k <= 3) ? 2'b01 : 2'b00, 0, 0, 0, 0, 0, "sel_glitch");
        for (int k = 1; k <= 10; k++) step(0, 0, 2'b01, 0, 0, 0, k >= 6, 0, "sel_on");
        for (int k = 1; k <= 8; k++)  step(0, 0, 2'b00, 0, 0, 0, k < 6, 0, "sel_off");
        // Into HOLD, then reset mid-debounce while btnS stays held.
        for (int k = 1; k <= 18; k++) step(k <= 8, 0, 2'b00, 0, k >= 7, 0, 0, 0, "run_to_hold");
        for (int k = 1; k <= 20; k++) step(1, 0, 2'b00, k == 5, (k < 5) || (k >= 12), 0, 0, 0, "rst_mid_press");
        for (int k = 1; k <= 12; k++) step(0, 0, 2'b00, 0, 1, 0, 0, 0, "rst_release");
`else
        // Short press toggles on release.
        for (int k = 1; k <= 19; k++) step(k <= 7, 0, 2'b00, 0, k >= 14, 0, 0, 0, "lp_short");
        // Long press in HOLD: single clear, stays paused, no toggle on release.
        for (int k = 1; k <= 42; k++) step(k <= 30, 0, 2'b00, 0, 1, k == 17, 0, 0, "lp_long");
`endif

        @(posedge clk);
        #2;
        check_bit("sb_drained", sb.size() == 0, 1'b1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
